// File: rtl/shifter_seq_if.sv
// Request/result bundle for the sequential shift/rotate unit.
// The master issues start/OP/A/N; the slave returns busy/done and the R/CCR result bus.
interface shifter_seq_if #(
    parameter int op_size  = 4,
    parameter int amt_size = 3
);
    logic                start;
    logic [2:0]          OP;
    logic [op_size-1:0]  A;
    logic [amt_size-1:0] N;
    logic                busy;
    logic                done;
    logic [op_size-1:0]  R;
    logic [3:0]          CCR;

    modport master (
        output start, OP, A, N,
        input  busy, done, R, CCR
    );

    modport slave (
        input  start, OP, A, N,
        output busy, done, R, CCR
    );
endinterface

// File: rtl/shifter_seq.sv
// Sequential shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Produces the result register R and the CVNZ condition codes on COMMIT.
module shifter_seq #(
    parameter int         op_size  = 4,
    parameter int         amt_size = 3,
    parameter logic [3:0] c_mask   = 4'b1000,
    parameter logic [3:0] v_mask   = 4'b0100,
    parameter logic [3:0] n_mask   = 4'b0010,
    parameter logic [3:0] z_mask   = 4'b0001
) (
    input  logic          clk,
    input  logic          rst_n,
    shifter_seq_if.slave  bus
);

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [op_size-1:0]  work_q,  work_d;
    logic [2:0]          mode_q,  mode_d;
    logic [amt_size-1:0] count_q, count_d;
    logic                c_q,     c_d;
    logic                v_q,     v_d;
    logic [op_size-1:0]  r_q,     r_d;
    logic [3:0]          ccr_q,   ccr_d;
    logic                done_q,  done_d;
    logic [op_size+1:0]  step_res;

    function automatic logic is_reserved(input logic [2:0] op);
        return (op > OP_ROR);
    endfunction

    // Returns {next_work, next_c, next_v} for a single 1-bit step.
    function automatic logic [op_size+1:0] step_fn(
        input logic [2:0]         mode,
        input logic [op_size-1:0] w,
        input logic               v
    );
        logic [op_size-1:0] nw;
        logic               nc;
        logic               nv;
        nw = w;
        nc = 1'b0;
        nv = 1'b0;
        case (mode)
            OP_SHL: begin
                nw = {w[op_size-2:0], 1'b0};
                nc = w[op_size-1];
                // V is sticky: set once the sign bit has flipped on any step
                nv = v | (w[op_size-1] ^ w[op_size-2]);
            end
            OP_SHR: begin
                nw = {1'b0, w[op_size-1:1]};
                nc = w[0];
            end
            OP_ASR: begin
                nw = {w[op_size-1], w[op_size-1:1]};
                nc = w[0];
            end
            OP_ROL: begin
                nw = {w[op_size-2:0], w[op_size-1]};
                nc = w[op_size-1];
            end
            OP_ROR: begin
                nw = {w[0], w[op_size-1:1]};
                nc = w[0];
            end
            default: begin
                nw = w;
                nc = 1'b0;
                nv = 1'b0;
            end
        endcase
        return {nw, nc, nv};
    endfunction

    function automatic logic [3:0] ccr_pack(
        input logic               c,
        input logic               v,
        input logic [op_size-1:0] w
    );
        logic [3:0] f;
        f = 4'b0000;
        if (c)            f = f | c_mask;
        if (v)            f = f | v_mask;
        if (w[op_size-1]) f = f | n_mask;
        if (w == '0)      f = f | z_mask;
        return f;
    endfunction

    assign step_res = step_fn(mode_q, work_q, v_q);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        count_d = count_q;
        c_d     = c_q;
        v_d     = v_q;
        r_d     = r_q;
        ccr_d   = ccr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.A;
                    mode_d  = bus.OP;
                    // Reserved modes skip the step loop entirely, leaving R=A
                    count_d = is_reserved(bus.OP) ? '0 : bus.N;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    work_d  = step_res[op_size+1:2];
                    c_d     = step_res[1];
                    v_d     = step_res[0];
                    count_d = count_q - 1'b1;
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                r_d     = work_q;
                ccr_d   = ccr_pack(c_q, v_q, work_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            mode_q  <= '0;
            count_q <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            r_q     <= '0;
            ccr_q   <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            c_q     <= c_d;
            v_q     <= v_d;
            r_q     <= r_d;
            ccr_q   <= ccr_d;
            done_q  <= done_d;
        end
    end

    // busy covers SHIFT and COMMIT, so it drops exactly when done rises
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.R    = r_q;
    assign bus.CCR  = ccr_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Scoreboard bench for shifter_seq: stimulus pushes model results, a monitor
// pops and compares them whenever done is presented.
module tb_shifter_seq;
    localparam int OPW = 4;
    localparam int AMW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shifter_seq_if #(.op_size(OPW), .amt_size(AMW)) bus ();

    shifter_seq #(
        .op_size (OPW),
        .amt_size(AMW),
        .c_mask  (4'b1000),
        .v_mask  (4'b0100),
        .n_mask  (4'b0010),
        .z_mask  (4'b0001)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [OPW-1:0] r;
        logic [3:0]     ccr;
        int             lat;
        int             t0;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Closed-form model: the whole shift is done at once in wide arithmetic.
    function automatic logic [OPW+3:0] model(input logic [2:0] op, input logic [OPW-1:0] a, input int n);
        logic [63:0]        w;
        logic [63:0]        fld;
        logic [63:0]        all1;
        logic signed [63:0] s;
        logic [2*OPW-1:0]   dd;
        logic [2*OPW-1:0]   t;
        logic [OPW-1:0]     r;
        logic               c;
        logic               v;
        int                 k;
        r = a;
        c = 1'b0;
        v = 1'b0;
        k = n % OPW;
        dd = {a, a};
        case (op)
            3'd0: begin
                w    = 64'(a) << n;
                r    = w[OPW-1:0];
                c    = (n > 0) && w[OPW];
                all1 = (64'd1 << (n + 1)) - 64'd1;
                fld  = (w >> (OPW - 1)) & all1;
                v    = (fld != 64'd0) && (fld != all1);
            end
            3'd1: begin
                w = (64'(a) << 1) >> n;
                r = w[OPW:1];
                c = (n > 0) && w[0];
            end
            3'd2: begin
                s = {{(64-OPW){a[OPW-1]}}, a};
                s = (s <<< 1) >>> n;
                r = s[OPW:1];
                c = (n > 0) && s[0];
            end
            3'd3: begin
                t = dd >> (OPW - k);
                r = t[OPW-1:0];
                c = (n > 0) && r[0];
            end
            3'd4: begin
                t = dd >> k;
                r = t[OPW-1:0];
                c = (n > 0) && r[OPW-1];
            end
            default: begin
                r = a;
            end
        endcase
        return {r, c, v, r[OPW-1], (r == '0)};
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_R", 32'(bus.R), 32'(e.r));
                chk("result_CCR", 32'(bus.CCR), 32'(e.ccr));
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                chk("busy_low_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done within %0d cycles expected done (t=%0t)", budget, $time);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [OPW-1:0] a,
                          input logic [AMW-1:0] n, input bit poke);
        exp_t           e;
        logic [OPW+3:0] m;
        m = model(op, a, int'(n));
        bus.start = 1'b1;
        bus.OP    = op;
        bus.A     = a;
        bus.N     = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.OP    = 3'($urandom);
        bus.A     = OPW'($urandom);
        bus.N     = AMW'($urandom);
        e.r   = m[OPW+3:4];
        e.ccr = m[3:0];
        e.lat = (op > 3'd4) ? 2 : int'(n) + 2;
        e.t0  = cyc;
        exp_q.push_back(e);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        if (poke) begin
            @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.A     = '1;
            bus.OP    = 3'b000;
            bus.N     = 3'd1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_done(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.OP    = 3'b000;
        bus.A     = '0;
        bus.N     = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_R", 32'(bus.R), 32'd0);
        chk("reset_CCR", 32'(bus.CCR), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'b000, 4'b1001, 3'd1, 1'b0);
        run_op(3'b010, 4'b1000, 3'd3, 1'b0);
        run_op(3'b011, 4'b1001, 3'd2, 1'b0);
        run_op(3'b001, 4'b0001, 3'd1, 1'b0);
        run_op(3'b000, 4'b0110, 3'd5, 1'b0);
        run_op(3'b000, 4'b1010, 3'd0, 1'b0);
        run_op(3'b000, 4'b0011, 3'd7, 1'b1);
        run_op(3'b110, 4'b0000, 3'd3, 1'b0);
        run_op(3'b100, 4'b1001, 3'd1, 1'b0);
        run_op(3'b010, 4'b0111, 3'd6, 1'b0);
        run_op(3'b000, 4'b1001, 3'd1, 1'b0);

        // Abort an SHL/7 run with an asynchronous reset in mid-cycle.
        bus.start = 1'b1;
        bus.OP    = 3'b000;
        bus.A     = 4'b0101;
        bus.N     = 3'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_R", 32'(bus.R), 32'd0);
        chk("abort_CCR", 32'(bus.CCR), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(3'b011, 4'b1001, 3'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), OPW'($urandom), AMW'($urandom), 1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shifter_seq.md
# shifter_seq

Parametrised sequential shift/rotate unit, the multi-bit, multi-mode successor to the single-step combinational left shifter in the ALU datapath. It shifts or rotates an `op_size`-bit operand by a variable amount, one bit position per clock, under a start/busy/done handshake. It produces the result and the 4-bit CVNZ condition code register. It sits beside the other ALU units and drives the shared R/CCR result bus.

## Interface
- `op_size`, default 4: operand and result width in bits (≥2).
- `amt_size`, default 3: width of the shift-amount input; amounts range 0..2^amt_size−1.
- `c_mask`/`v_mask`/`n_mask`/`z_mask`, default 'b1000/'b0100/'b0010/'b0001: CCR bit positions (CVNZ order).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `OP`  in  3  mode: 000 SHL, 001 SHR (logical), 010 ASR, 011 ROL, 100 ROR, 101–111 reserved.
- `A`  in  op_size  operand.
- `N`  in  amt_size  shift amount.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when R/CCR are updated.
- `R`  out  op_size  result register.
- `CCR`  out  4  condition codes, CVNZ.

## Operation
- States: IDLE, SHIFT, COMMIT.
- **IDLE**:
  - `start`=1 at a clock edge latches `A`, `OP` and `N` into internal work, mode and count registers.
  - Clears the internal C and V accumulators, sets `busy`, and moves to SHIFT.
  - Inputs changing after capture have no effect.
- **SHIFT**:
  - count≠0: perform one 1-bit step on work, update C, decrement count.
  - count=0: go to COMMIT.
- Step rules per mode:
  - SHL: work<<1, LSB←0, C←old MSB; V set (sticky) if the MSB changes value on this step.
  - SHR: work>>1, MSB←0, C←old LSB; V←0.
  - ASR: work>>1, MSB preserved, C←old LSB; V←0.
  - ROL: MSB rotates into LSB, C←old MSB; V←0.
  - ROR: LSB rotates into MSB, C←old LSB; V←0.
  - Reserved: no step performed; count is forced to 0, giving R=A, C=0, V=0.
- Amount 0: work unchanged, C=0, V=0.
- Amount ≥ `op_size` is iterated fully; no saturation or modulo. Example: SHL 4-bit by 5 yields 0000.
- **COMMIT**:
  - R←work.
  - CCR←{C, V, N=work[MSB], Z=(work==0)}.
  - `done`=1, `busy`=0, then return to IDLE.
- R and CCR hold their values until the next COMMIT. All four CCR bits are rewritten at every COMMIT; none are cleared at start.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Reset (asynchronous, any state): state=IDLE, R=0, CCR=0000, `busy`=0, `done`=0, internal registers cleared.
- Reset mid-operation aborts the operation: no `done`, and R/CCR become 0.
- Let the start edge be edge 0 with amount n:
  - `busy`=1 after edge 0.
  - Shift steps occur on edges 1..n.
  - The count=0 check takes one further edge; COMMIT occurs on edge n+2.
  - After edge n+2: R/CCR valid, `done`=1 for exactly one cycle, `busy`=0.
  - Latency from start edge to valid outputs is n+2 cycles.
- Reserved OP or n=0: COMMIT on edge 2.
- `start` held high during the `done` cycle is accepted at the next edge, since the state is already IDLE. Back-to-back throughput is one operation per n+3 cycles.
- `busy` and `done` are never high simultaneously.

## Test plan
Parameters: `op_size`=4, `amt_size`=3.
- **SHL, A=1001, N=1**: `done` after edge 3; R=0010, CCR=1100 (C=1, V=1). `busy` high for edges 0–2.
- **ASR, A=1000, N=3**: R=1111, CCR=0010. `done` after edge 5.
- **ROL, A=1001, N=2**: R=0110, CCR=0000. **SHR, A=0001, N=1**: R=0000, CCR=1001.
- **SHL, A=0110, N=5**: R=0000, CCR=0101 (V sticky from step 1, C=0 from the last step). **SHL, A=1010, N=0**: R=1010, CCR=0010, `done` after edge 2.
- **Ignored start**: pulse `start` with A=1111 at edge 2 of an SHL/N=7 run → ignored; result reflects the original operands only. **Reserved OP=110, A=0000**: R=0000, CCR=0001, `done` after edge 2.
- **Reset mid-operation**: deassert `rst_n` asynchronously mid-cycle during an SHL/N=7 run → R=0, CCR=0000, `busy`=0 immediately, no `done`. A new start after release runs normally.
